// File: rtl/btn_pkg.sv
// Shared types and default constants for the button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 1 ms of stability at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce FSM, press/release pulses.
// Auto-repeat on a held button is built only when BTN_REPEAT_EN is defined.
//
// state        | meaning
// IDLE         | released, level 0
// PRESS_WAIT   | input high, counting stable cycles before accepting press
// HELD         | pressed, level 1 (repeat timer runs here when enabled)
// RELEASE_WAIT | input low, counting stable cycles before accepting release
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic bi,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE         = IDLE;
  localparam logic [1:0] ST_PRESS_WAIT   = PRESS_WAIT;
  localparam logic [1:0] ST_HELD         = HELD;
  localparam logic [1:0] ST_RELEASE_WAIT = RELEASE_WAIT;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   rpt_fire;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], bi};
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef BTN_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_next;
  logic [RPT_W-1:0] rpt_target;
  logic             rpt_armed;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
  assign rpt_next   = rpt_cnt + RPT_W'(1);
  assign rpt_target = rpt_armed ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);
  assign rpt_fire   = (state == ST_HELD) && s && (rpt_next == rpt_target);

  always_ff @(posedge clk) begin
    if (reset || state != ST_HELD || !s) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_next;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
  assign rpt_fire   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          level <= 1'b0;
          if (s) begin
            state <= ST_PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_TERM) begin
            state <= ST_HELD;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          level <= 1'b1;
          if (!s) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end else if (rpt_fire) begin
            press <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_TERM) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent debounced button channels; auto-repeat under BTN_REPEAT_EN.
// The release output is named release_pulse because "release" is a reserved word.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] bi,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .bi           (bi[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a run-length debounce model predicts level/press/release every cycle.
module tb_button_conditioner;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] bi;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;

  button_conditioner #(
    .N_BTN          (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bi           (bi),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } obs_t;

  obs_t         exp_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           cycle      = 0;

  // Reference model: a level change is accepted once the synchronised input
  // has disagreed with the accepted level for DEB+1 consecutive samples.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl;
  int           run[N];
  int           held_t[N];

  task automatic model_step();
    obs_t         e;
    logic [N-1:0] s;
    e = '0;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_back('0);
      m_lvl = '0;
      for (int i = 0; i < N; i++) begin
        run[i]    = 0;
        held_t[i] = 0;
      end
    end else begin
      s = hist.pop_front();
      hist.push_back(bi);
      for (int i = 0; i < N; i++) begin
        if (s[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == DEB + 1) begin
            m_lvl[i]  = s[i];
            run[i]    = 0;
            held_t[i] = 0;
            if (s[i]) e.prs[i] = 1'b1;
            else      e.rel[i] = 1'b1;
          end
        end else begin
`ifdef BTN_REPEAT_EN
          if (m_lvl[i]) begin
            if (run[i] > 0) held_t[i] = 0;
            else begin
              held_t[i]++;
              if (held_t[i] == RD || (held_t[i] > RD && (held_t[i] - RD) % RP == 0))
                e.prs[i] = 1'b1;
            end
          end
`endif
          run[i] = 0;
        end
      end
    end
    e.lvl = m_lvl;
    exp_q.push_back(e);
  endtask

  initial begin
    for (int k = 0; k < SYNC; k++) hist.push_back('0);
    m_lvl = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: outputs are presented every cycle, compare against the oldest prediction
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (level !== e.lvl || press !== e.prs || release_pulse !== e.rel) begin
          mismatched++;
          $display("FAIL outputs cycle %0d: level/press/release got %b/%b/%b required %b/%b/%b",
                   cycle, level, press, release_pulse, e.lvl, e.prs, e.rel);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [11:0] bounce_pat;

  initial begin
    reset = 1'b1;
    bi    = '0;
    bounce_pat = 12'b110111111111;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    bi[0] = 1'b1;
    cyc(15);

    for (int k = 11; k >= 0; k--) begin
      bi[1] = bounce_pat[k];
      cyc(1);
    end
    cyc(6);
    bi[1] = 1'b0;
    cyc(10);
    bi[1] = 1'b1;
    cyc(3);
    bi[1] = 1'b0;
    cyc(10);

    bi[0] = 1'b0;
    cyc(12);

    bi = '1;
    cyc(12);
    bi = '0;
    cyc(12);

    bi[2] = 1'b1;
    cyc(4);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(12);
    bi[2] = 1'b0;
    cyc(12);

    bi[3] = 1'b1;
    cyc(30);
    bi[3] = 1'b0;
    cyc(20);

    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) bi[i] = ~bi[i];
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 1'b0;
    bi    = '0;
    cyc(20);

    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
